calculator_core: RTL and testbench
==================================

# calculator_core

Accumulating 8-bit adder calculator with a four-digit seven-segment readout. The user sets an operand on `in` and presses `plus` to add it to a running sum, or `equal` to add it and show the total. The block sits between the board switches/buttons and the four-digit display. It contains a button front end, an accumulator datapath, a binary-to-BCD converter and segment decoders.

## Interface

Parameters:
- `SAT_MAX`, default 9999: saturation ceiling for the accumulator and the result.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  8  unsigned operand (switches), sampled by a register each cycle.
- `plus`  in  1  active-low "add" button, asynchronous to `clk`.
- `equal`  in  1  active-low "equals" button, asynchronous to `clk`.
- `seg1`  out  7  thousands digit, active-low segments; bit6..bit0 = g..a.
- `seg2`  out  7  hundreds digit, same encoding.
- `seg3`  out  7  tens digit, same encoding.
- `seg4`  out  7  ones digit, same encoding.

## Operation

Internal named signals, probed by verification:
- `seg_in` (8 b): registered `in`.
- `result` (14 b): last total.
- `seg_display` (14 b): value currently shown.

Button front end:
- Each button passes through a 2-flop synchronizer, then a falling-edge detector.
- The detector output is a one-cycle event. Holding a button low produces one event.

Modes: ENTRY and RESULT.
- ENTRY: `seg_display` = `seg_in`.
- RESULT: `seg_display` = `result`.

Event handling:
- **plus** event: `acc` ← min(`acc` + `seg_in`, `SAT_MAX`); mode ← ENTRY.
- **equal** event: `result` ← min(`acc` + `seg_in`, `SAT_MAX`); `acc` ← 0; mode ← RESULT.
- **plus and equal in the same cycle:** equal wins; plus is dropped.
- **In RESULT, `seg_in` differs from its previous registered value:** mode ← ENTRY. `result` is retained.
- **equal with `acc` = 0:** `result` = `seg_in`.

Display path:
- `seg_display` is converted to 4 BCD digits (sequential double-dabble or combinational divide-free conversion).
- Each digit is decoded to segments: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h.
- Leading zeros are blanked (7Fh) on seg1..seg3. seg4 always shows a digit.

Reset (`rst`=1 at a rising edge):
- `acc`, `result`, `seg_in` ← 0; mode ← ENTRY.
- Synchronizer flops ← 1 (released button).
- seg1..seg3 ← 7Fh; seg4 ← 40h, i.e. display reads "0".
- Reset mid-operation discards a pending sum and any in-flight button event.

## Timing

- A button low is first sampled at edge N.
- The event is asserted during cycle N+2 (after two synchronizer stages and the edge compare).
- `acc`/`result`/mode update at edge N+3.
- `seg_display` is combinational from mode, `seg_in` and `result`. seg1..seg4 are registered.
  - With a combinational BCD converter, segments reflect the new value at edge N+4.
  - A sequential converter may add at most 16 cycles. Outputs hold their old value until conversion completes, with no glitching through intermediate codes.
- `in` change to segment update: 2 cycles (1 for `seg_in`, 1 for the output register), plus the converter latency if sequential.
- A button must stay low across at least 2 rising edges to be guaranteed to register. Shorter pulses may be missed.

## Structure

- Shared package `calc_pkg`:
  - segment code constants, including BLANK = 7Fh;
  - `SAT_MAX` default;
  - mode enum {ENTRY, RESULT}.
- One natural sub-module `bcd7seg`: 4-bit BCD plus blank flag in, 7-bit active-low segments out. Instantiate four times.
- Synchronizer/edge detect and the binary-to-BCD converter stay inline.

## Test plan

- Reset, then idle → seg1..seg3 = 7Fh, seg4 = 40h; `result` = 0.
- `in`=15, press plus; `in`=2, press equal → `result` = 17; segments show blank, blank, 1 (79h), 7 (78h).
- Then `in`=7 (display returns to ENTRY, shows 7); plus; `in`=3; equal → `result` = 10. Then `in`=8 → display shows 8.
- Chaining: 255 plus, 255 plus, 255 equal → `result` = 765; display "765".
- Saturation: preload `acc` to 9990 via repeated plus; `in`=20, equal → `result` = 9999.
- Simultaneous plus+equal falling edge with `acc`=5, `in`=4 → `result` = 9, `acc` = 0.
- Assert `rst` mid-sequence, after plus with `in`=50 → `acc` = 0; next equal with `in`=1 gives `result` = 1.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants, segment codes and mode type for the accumulating calculator.
package calc_pkg;

    localparam int SAT_MAX_DEF = 9999;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {ENTRY, RESULT} mode_t;

    // Active-low segments, bit6..bit0 = g..a.
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd7seg.sv
// One BCD digit to active-low seven-segment code, with a blanking override.
module bcd7seg
    import calc_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : seg_code(digit);
    end

endmodule

// File: rtl/calculator_core.sv
// Accumulating 8-bit adder with button synchronizers, saturating sum,
// combinational binary-to-BCD and a registered four-digit segment readout.
module calculator_core
    import calc_pkg::*;
#(
    parameter int SAT_MAX = SAT_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic       plus,
    input  logic       equal,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic [6:0] seg4
);

    localparam logic [14:0] SAT15 = 15'(SAT_MAX);

    logic [7:0]  seg_in, seg_in_prev;
    logic [13:0] acc, result, seg_display;
    logic [2:0]  plus_sh, equal_sh;
    logic        plus_ev, equal_ev;
    mode_t       mode, mode_nxt;
    logic [14:0] sum;
    logic [13:0] sum_sat;

    // [0],[1] synchronize; [2] is the history bit for the falling-edge compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            plus_sh  <= 3'b111;
            equal_sh <= 3'b111;
            plus_ev  <= 1'b0;
            equal_ev <= 1'b0;
        end else begin
            plus_sh  <= {plus_sh[1:0], plus};
            equal_sh <= {equal_sh[1:0], equal};
            plus_ev  <= plus_sh[2] & ~plus_sh[1];
            equal_ev <= equal_sh[2] & ~equal_sh[1];
        end
    end

    always_comb begin
        sum     = {1'b0, acc} + {7'd0, seg_in};
        sum_sat = (sum > SAT15) ? SAT15[13:0] : sum[13:0];
    end

    always_comb begin
        mode_nxt = mode;
        if (equal_ev)
            mode_nxt = RESULT;
        else if (plus_ev)
            mode_nxt = ENTRY;
        else if (mode == RESULT && seg_in != seg_in_prev)
            mode_nxt = ENTRY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode        <= ENTRY;
            seg_in      <= 8'd0;
            seg_in_prev <= 8'd0;
            acc         <= 14'd0;
            result      <= 14'd0;
        end else begin
            mode        <= mode_nxt;
            seg_in      <= in;
            seg_in_prev <= seg_in;
            if (equal_ev) begin
                result <= sum_sat;
                acc    <= 14'd0;
            end else if (plus_ev) begin
                acc    <= sum_sat;
            end
        end
    end

    assign seg_display = (mode == RESULT) ? result : {6'd0, seg_in};

    // Double-dabble unrolled; the value never exceeds 9999 so four digits suffice.
    logic [29:0] dd;
    always_comb begin
        dd = {16'd0, seg_display};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (dd[14+4*d +: 4] >= 4'd5)
                    dd[14+4*d +: 4] = dd[14+4*d +: 4] + 4'd3;
            end
            dd = dd << 1;
        end
    end

    logic [3:0] dig3, dig2, dig1, dig0;
    logic       blk3, blk2, blk1;
    logic [6:0] s3, s2, s1, s0;

    assign dig3 = dd[29:26];
    assign dig2 = dd[25:22];
    assign dig1 = dd[21:18];
    assign dig0 = dd[17:14];
    assign blk3 = (dig3 == 4'd0);
    assign blk2 = blk3 && (dig2 == 4'd0);
    assign blk1 = blk2 && (dig1 == 4'd0);

    bcd7seg u_thou (.digit(dig3), .blank(blk3), .seg(s3));
    bcd7seg u_hund (.digit(dig2), .blank(blk2), .seg(s2));
    bcd7seg u_tens (.digit(dig1), .blank(blk1), .seg(s1));
    bcd7seg u_ones (.digit(dig0), .blank(1'b0), .seg(s0));

    always_ff @(posedge clk) begin
        if (rst) begin
            seg1 <= SEG_BLANK;
            seg2 <= SEG_BLANK;
            seg3 <= SEG_BLANK;
            seg4 <= 7'h40;
        end else begin
            seg1 <= s3;
            seg2 <= s2;
            seg3 <= s1;
            seg4 <= s0;
        end
    end

endmodule

// File: tb/tb_calculator_core.sv
// Self-checking bench: test-plan vector table, hand sequences for timing and
// reset corners, and random press sequences against a transaction-level model.
module tb_calculator_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in = 8'd0;
    logic       plus = 1'b1;
    logic       equal = 1'b1;
    logic [6:0] seg1, seg2, seg3, seg4;

    calculator_core dut (
        .clk(clk), .rst(rst), .in(in), .plus(plus), .equal(equal),
        .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model, updated once per user action.
    int m_acc = 0, m_result = 0, m_in = 0;
    bit m_result_mode = 0;

    typedef struct {
        int op;   // 0 set in, 1 plus, 2 equal, 3 plus+equal together
        int val;
        int er;   // expected result
        int ed;   // expected displayed value
    } vec_t;
    vec_t tbl[$];

    function automatic int sat(int x);
        return (x > 9999) ? 9999 : x;
    endfunction

    function automatic logic [6:0] code(int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // pos 1 = thousands .. 4 = ones; leading zeros blank except the ones digit.
    function automatic int exp_seg(int v, int pos);
        int div;
        case (pos)
            1: div = 1000;
            2: div = 100;
            3: div = 10;
            default: div = 1;
        endcase
        if (pos < 4 && v < div) return 'h7F;
        return int'(code((v / div) % 10));
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_segs(string name, int v);
        chk({name, ".seg1"}, int'(seg1), exp_seg(v, 1));
        chk({name, ".seg2"}, int'(seg2), exp_seg(v, 2));
        chk({name, ".seg3"}, int'(seg3), exp_seg(v, 3));
        chk({name, ".seg4"}, int'(seg4), exp_seg(v, 4));
    endtask

    task automatic check_all(string name, int er, int ed);
        chk({name, ".result"}, int'(dut.result), er);
        chk({name, ".display"}, int'(dut.seg_display), ed);
        chk({name, ".acc"}, int'(dut.acc), m_acc);
        chk({name, ".seg_in"}, int'(dut.seg_in), m_in);
        chk_segs(name, ed);
    endtask

    function automatic int m_disp();
        return m_result_mode ? m_result : m_in;
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(int v);
        in = v[7:0];
        tick(3);
        if (m_result_mode && v != m_in) m_result_mode = 0;
        m_in = v;
    endtask

    task automatic press(bit p, bit e, int hold);
        plus  = ~p;
        equal = ~e;
        tick(hold);
        plus  = 1'b1;
        equal = 1'b1;
        tick(5);
        if (e) begin
            m_result = sat(m_acc + m_in);
            m_acc = 0;
            m_result_mode = 1;
        end else if (p) begin
            m_acc = sat(m_acc + m_in);
            m_result_mode = 0;
        end
    endtask

    initial begin
        tick(3);
        chk_segs("reset_held", 0);
        chk("reset_held.result", int'(dut.result), 0);
        rst = 1'b0;
        tick(4);
        check_all("reset_idle", 0, 0);

        tbl.push_back('{0, 15, 0, 15});
        tbl.push_back('{1, 0, 0, 15});
        tbl.push_back('{0, 2, 0, 2});
        tbl.push_back('{2, 0, 17, 17});
        tbl.push_back('{0, 7, 17, 7});
        tbl.push_back('{1, 0, 17, 7});
        tbl.push_back('{0, 3, 17, 3});
        tbl.push_back('{2, 0, 10, 10});
        tbl.push_back('{0, 8, 10, 8});
        tbl.push_back('{0, 255, 10, 255});
        tbl.push_back('{1, 0, 10, 255});
        tbl.push_back('{1, 0, 10, 255});
        tbl.push_back('{2, 0, 765, 765});
        tbl.push_back('{0, 5, 765, 5});
        tbl.push_back('{1, 0, 765, 5});
        tbl.push_back('{0, 4, 765, 4});
        tbl.push_back('{3, 0, 9, 9});
        foreach (tbl[i]) begin
            case (tbl[i].op)
                0: set_in(tbl[i].val);
                1: press(1, 0, 3);
                2: press(0, 1, 3);
                default: press(1, 1, 3);
            endcase
            check_all($sformatf("vec%0d", i), tbl[i].er, tbl[i].ed);
        end
        chk("simul.acc_zero", int'(dut.acc), 0);

        // Saturation: 39*255 + 45 = 9990, then +20 clamps to 9999.
        set_in(255);
        for (int i = 0; i < 39; i++) press(1, 0, 2);
        set_in(45);
        press(1, 0, 3);
        chk("sat.preload", int'(dut.acc), 9990);
        set_in(20);
        press(0, 1, 3);
        check_all("sat", 9999, 9999);

        // Reset mid-sequence discards the pending sum.
        set_in(50);
        press(1, 0, 3);
        chk("rst_mid.pre_acc", int'(dut.acc), 50);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        m_acc = 0; m_result = 0; m_result_mode = 0;
        tick(3);
        check_all("rst_mid", 0, 50);
        set_in(1);
        press(0, 1, 3);
        check_all("rst_mid.equal", 1, 1);

        // Latency: button low sampled at edge N, result at N+3, segments at N+4.
        set_in(30);
        press(1, 0, 3);
        set_in(12);
        equal = 1'b0;
        tick(3);
        chk("lat.n2_result", int'(dut.result), 1);
        tick(1);
        chk("lat.n3_result", int'(dut.result), 42);
        chk("lat.n3_seg3", int'(seg3), exp_seg(12, 3));
        tick(1);
        chk("lat.n4_seg3", int'(seg3), exp_seg(42, 3));
        chk("lat.n4_seg4", int'(seg4), exp_seg(42, 4));
        equal = 1'b1;
        tick(5);
        m_result = 42; m_acc = 0; m_result_mode = 1;
        check_all("lat.final", 42, 42);

        // Holding a button for many cycles must add only once.
        set_in(9);
        press(1, 0, 12);
        chk("hold.acc", int'(dut.acc), 9);

        for (int i = 0; i < 60; i++) begin
            int op;
            if ($urandom_range(0, 3) != 0) set_in(int'($urandom_range(0, 255)));
            op = int'($urandom_range(0, 5));
            if (op < 3)      press(1, 0, int'($urandom_range(2, 6)));
            else if (op < 5) press(0, 1, int'($urandom_range(2, 6)));
            else             press(1, 1, int'($urandom_range(2, 6)));
            check_all($sformatf("rand%0d", i), m_result, m_disp());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
